// File: rtl/pll_lock_supervisor_if.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor_if
// Purpose : groups the PLL supervision signals that pass between the
//           supervisor and the rPLL wrapper / downstream reset logic.
// Signals :
//   pll_lock     - rPLL LOCK, asynchronous to clkin
//   force_relock - single-cycle request to restart the lock sequence
//   pll_reset    - drives rPLL RESET
//   sys_rst      - active-high reset request for the PLL output domains
//   ready        - high only while the PLL is qualified and running
//   fault        - high only in the sticky fault state
//   retry_cnt    - failed lock attempts since the last lock or force_relock
//   relock_cnt   - saturating count of automatic relocks from RUN
// Modports:
//   master - the supervisor (reads lock/request, drives status)
//   slave  - the environment (drives lock/request, reads status)
// ---------------------------------------------------------------------------
interface pll_lock_supervisor_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  logic               pll_lock;
  logic               force_relock;
  logic               pll_reset;
  logic               sys_rst;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [7:0]         relock_cnt;

  modport master (
    input  pll_lock,
    input  force_relock,
    output pll_reset,
    output sys_rst,
    output ready,
    output fault,
    output retry_cnt,
    output relock_cnt
  );

  modport slave (
    output pll_lock,
    output force_relock,
    input  pll_reset,
    input  sys_rst,
    input  ready,
    input  fault,
    input  retry_cnt,
    input  relock_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
// Purpose : sequences the Gowin rPLL after power-up, synchronises its LOCK
//           output, qualifies lock as stable and only then releases the
//           reset request for logic on the PLL output clocks. Lock timeouts
//           are retried a bounded number of times before a sticky fault.
// Ports   :
//   clkin  - PLL reference clock, the only clock of this block
//   rst    - asynchronous active-high reset
//   sup_if - pll_lock_supervisor_if.master (lock input, relock request,
//            pll_reset / sys_rst / ready / fault / retry_cnt / relock_cnt)
// Config  : define PLL_SUP_AUTORELOCK_EN to restart the sequence on lock
//           loss in RUN (counted in relock_cnt); without it lock loss in
//           RUN is a fault and relock_cnt is constant zero.
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                    clkin,
  input  logic                    rst,
  pll_lock_supervisor_if.master   sup_if
);

  // One shared counter must hold the largest terminal count of any state.
  localparam int CNT_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntNext;
  logic [RETRY_W-1:0] r_retryCnt;
  logic [RETRY_W-1:0] w_retryNext;
  logic [RETRY_W-1:0] w_retryInc;
  logic               r_sync1;
  logic               r_lockS;

  // Two-flop synchroniser for the asynchronous LOCK pin; r_lockS is the
  // only copy of lock the FSM ever looks at.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_lockS <= 1'b0;
    end else begin
      r_sync1 <= sup_if.pll_lock;
      r_lockS <= r_sync1;
    end
  end

  // State, shared counter and retry count all advance together from the
  // next-state logic below.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_state    <= ST_PLL_RST;
      r_cnt      <= '0;
      r_retryCnt <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_retryCnt <= w_retryNext;
    end
  end

  assign w_retryInc = r_retryCnt + RETRY_W'(1);

`ifdef PLL_SUP_AUTORELOCK_EN
  logic       w_relockBump;
  logic [7:0] r_relockCnt;

  // Relock events saturate rather than wrap so a flapping PLL never looks
  // healthier than it is; only rst clears the count.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_relockCnt <= 8'd0;
    end else if (w_relockBump && (r_relockCnt != 8'hFF)) begin
      r_relockCnt <= r_relockCnt + 8'd1;
    end
  end

  assign sup_if.relock_cnt = r_relockCnt;
`else
  assign sup_if.relock_cnt = 8'd0;
`endif

  // Next-state logic. force_relock overrides everything, including the
  // STABLE->RUN completion in the same cycle. Each state leaves on its own
  // terminal count, so the shared counter never wraps.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_retryNext = r_retryCnt;
`ifdef PLL_SUP_AUTORELOCK_EN
    w_relockBump = 1'b0;
`endif
    if (sup_if.force_relock) begin
      w_stateNext = ST_PLL_RST;
      w_cntNext   = '0;
      w_retryNext = '0;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == RESET_LAST) begin
            w_stateNext = ST_WAIT_LOCK;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (r_lockS) begin
            w_stateNext = ST_STABLE;
            w_cntNext   = '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_cntNext   = '0;
            w_retryNext = w_retryInc;
            w_stateNext = (w_retryInc == RETRY_LIMIT) ? ST_FAULT : ST_PLL_RST;
          end else begin
            w_cntNext = r_cnt + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          // A single low sample sends us back to WAIT_LOCK with a fresh
          // timeout; it is not counted as a failed attempt.
          if (!r_lockS) begin
            w_stateNext = ST_WAIT_LOCK;
            w_cntNext   = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_stateNext = ST_RUN;
            w_cntNext   = '0;
            w_retryNext = '0;
          end else begin
            w_cntNext = r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!r_lockS) begin
            w_cntNext = '0;
`ifdef PLL_SUP_AUTORELOCK_EN
            w_stateNext  = ST_PLL_RST;
            w_retryNext  = '0;
            w_relockBump = 1'b1;
`else
            w_stateNext = ST_FAULT;
`endif
          end
        end
        ST_FAULT: begin
          w_stateNext = ST_FAULT;
        end
        default: begin
          w_stateNext = ST_PLL_RST;
          w_cntNext   = '0;
        end
      endcase
    end
  end

  // Moore outputs straight from the state register; in reset the state is
  // PLL_RST so sys_rst is held asserted asynchronously.
  assign sup_if.pll_reset = (r_state == ST_PLL_RST) || (r_state == ST_FAULT);
  assign sup_if.sys_rst   = (r_state != ST_RUN);
  assign sup_if.ready     = (r_state == ST_RUN);
  assign sup_if.fault     = (r_state == ST_FAULT);
  assign sup_if.retry_cnt = r_retryCnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Purpose : self-checking bench for pll_lock_supervisor with
//           RESET_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRIES=3.
//           A phase/elapsed-time reference model predicts every output on
//           every clock; table vectors and short hand sequences add fixed
//           expectations for the documented timing points.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int RC = 4;
  localparam int LT = 16;
  localparam int SC = 8;
  localparam int MR = 3;

  logic clkin = 1'b0;
  logic rst   = 1'b0;

  pll_lock_supervisor_if #(.MAX_RETRIES(MR)) sup ();

  pll_lock_supervisor #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR)
  ) dut (
    .clkin (clkin),
    .rst   (rst),
    .sup_if(sup.master)
  );

  always #5 clkin = ~clkin;

  int nChecks = 0;
  int nErrors = 0;
  int edgeNum = 0;

  // Reference model: which phase the supervisor should be in, how long it
  // has been there, and the lock history seen through the synchroniser.
  typedef enum int {M_RESET, M_WAIT, M_STABLE, M_RUN, M_FAULT} phase_t;
  phase_t mPhase;
  int     mAge;
  int     mRetries;
  int     mRelocks;
  logic   lockHist[$];

  typedef struct {
    logic lock;
    logic frc;
    int   cycles;
    logic expPllReset;
    logic expSysRst;
    logic expReady;
    logic expFault;
    int   expRetry;
  } vec_t;

  vec_t vecs[15];

  // Compare one value and log it when it disagrees.
  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edgeNum, act, exp);
    end
  endtask

  task automatic modelReset();
    mPhase   = M_RESET;
    mAge     = 0;
    mRetries = 0;
    mRelocks = 0;
    lockHist.delete();
  endtask

  // Advance the model by one clock given the inputs sampled on that edge.
  // The lock value acting on this edge is the one sampled two edges ago.
  task automatic modelStep(input logic lock, input logic frc);
    logic lsUsed;
    lsUsed = (lockHist.size() >= 2) ? lockHist[lockHist.size() - 2] : 1'b0;
    lockHist.push_back(lock);
    if (lockHist.size() > 2) void'(lockHist.pop_front());
    if (frc) begin
      mPhase   = M_RESET;
      mAge     = 0;
      mRetries = 0;
    end else begin
      case (mPhase)
        M_RESET: begin
          mAge++;
          if (mAge == RC) begin mPhase = M_WAIT; mAge = 0; end
        end
        M_WAIT: begin
          mAge++;
          if (lsUsed) begin
            mPhase = M_STABLE; mAge = 0;
          end else if (mAge == LT) begin
            mRetries++;
            mAge   = 0;
            mPhase = (mRetries == MR) ? M_FAULT : M_RESET;
          end
        end
        M_STABLE: begin
          if (!lsUsed) begin
            mPhase = M_WAIT; mAge = 0;
          end else begin
            mAge++;
            if (mAge == SC) begin mPhase = M_RUN; mRetries = 0; end
          end
        end
        M_RUN: begin
          if (!lsUsed) begin
`ifdef PLL_SUP_AUTORELOCK_EN
            mPhase   = M_RESET;
            mAge     = 0;
            mRetries = 0;
            if (mRelocks < 255) mRelocks++;
`else
            mPhase = M_FAULT;
`endif
          end
        end
        default: ;
      endcase
    end
  endtask

  // Drive inputs for one clock, let the edge happen, then compare every
  // output against the model.
  task automatic applyStimulus(input logic lock, input logic frc);
    sup.pll_lock     = lock;
    sup.force_relock = frc;
    @(posedge clkin);
    #1;
    edgeNum++;
    modelStep(lock, frc);
    checkOutput("model.pll_reset", int'(sup.pll_reset), int'(mPhase == M_RESET || mPhase == M_FAULT));
    checkOutput("model.sys_rst", int'(sup.sys_rst), int'(mPhase != M_RUN));
    checkOutput("model.ready", int'(sup.ready), int'(mPhase == M_RUN));
    checkOutput("model.fault", int'(sup.fault), int'(mPhase == M_FAULT));
    checkOutput("model.retry_cnt", int'(sup.retry_cnt), mRetries);
    checkOutput("model.relock_cnt", int'(sup.relock_cnt), mRelocks);
  endtask

  task automatic expectNow(input string tag, input int pr, input int sr,
                           input int rd, input int ft, input int rt);
    checkOutput({tag, ".pll_reset"}, int'(sup.pll_reset), pr);
    checkOutput({tag, ".sys_rst"}, int'(sup.sys_rst), sr);
    checkOutput({tag, ".ready"}, int'(sup.ready), rd);
    checkOutput({tag, ".fault"}, int'(sup.fault), ft);
    checkOutput({tag, ".retry_cnt"}, int'(sup.retry_cnt), rt);
  endtask

  // Assert reset (asynchronously, wherever we are), confirm the reset
  // values appear without a clock, then release just after a falling edge
  // so the next rising edge is edge 1.
  task automatic doReset();
    rst              = 1'b1;
    sup.pll_lock     = 1'b0;
    sup.force_relock = 1'b0;
    #1;
    expectNow("reset", 1, 1, 0, 0, 0);
    checkOutput("reset.relock_cnt", int'(sup.relock_cnt), 0);
    repeat (2) @(posedge clkin);
    @(negedge clkin);
    rst = 1'b0;
    modelReset();
    edgeNum = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", nErrors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic lockVal;
    int   segLeft;

    sup.pll_lock     = 1'b0;
    sup.force_relock = 1'b0;
    #2;

    // Table: clean start, force_relock out of RUN, three lock timeouts to
    // FAULT, then force_relock back to a clean lock. Edges noted at right.
    vecs[0]  = '{1'b1, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 0}; // 3
    vecs[1]  = '{1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 0}; // 4
    vecs[2]  = '{1'b1, 1'b0, 8,  1'b0, 1'b1, 1'b0, 1'b0, 0}; // 12
    vecs[3]  = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 0}; // 13
    vecs[4]  = '{1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b1, 1'b0, 0}; // 18
    vecs[5]  = '{1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b0, 0}; // 19
    vecs[6]  = '{1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b0, 1'b0, 0}; // 23
    vecs[7]  = '{1'b0, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b0, 0}; // 38
    vecs[8]  = '{1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 1}; // 39
    vecs[9]  = '{1'b0, 1'b0, 20, 1'b1, 1'b1, 1'b0, 1'b0, 2}; // 59
    vecs[10] = '{1'b0, 1'b0, 19, 1'b0, 1'b1, 1'b0, 1'b0, 2}; // 78
    vecs[11] = '{1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b1, 3}; // 79
    vecs[12] = '{1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b0, 1'b1, 3}; // 89
    vecs[13] = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b0, 0}; // 90
    vecs[14] = '{1'b1, 1'b0, 13, 1'b0, 1'b0, 1'b1, 1'b0, 0}; // 103

    doReset();
    for (int v = 0; v < 15; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) applyStimulus(vecs[v].lock, vecs[v].frc);
      expectNow($sformatf("vec%0d", v), int'(vecs[v].expPllReset), int'(vecs[v].expSysRst),
                int'(vecs[v].expReady), int'(vecs[v].expFault), vecs[v].expRetry);
    end

    // Lock never arrives from reset: FAULT exactly on edge 60.
    doReset();
    for (int c = 0; c < 59; c++) applyStimulus(1'b0, 1'b0);
    checkOutput("nolock.fault_before", int'(sup.fault), 0);
    applyStimulus(1'b0, 1'b0);
    expectNow("nolock.e60", 1, 1, 0, 1, 3);
    applyStimulus(1'b0, 1'b1);
    expectNow("nolock.force", 1, 1, 0, 0, 0);

    // Glitchy lock: high 5, low 1, high. STABLE restarts, ready on edge 17.
    doReset();
    for (int c = 0; c < 5; c++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 1'b0);
    expectNow("glitch.e16", 0, 1, 0, 0, 0);
    applyStimulus(1'b1, 1'b0);
    expectNow("glitch.e17", 0, 0, 1, 0, 0);

    // Lock loss in RUN for two cycles.
    doReset();
    for (int c = 0; c < 13; c++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("loss.ready_e15", int'(sup.ready), 1);
    applyStimulus(1'b1, 1'b0);
`ifdef PLL_SUP_AUTORELOCK_EN
    expectNow("loss.e16", 1, 1, 0, 0, 0);
    checkOutput("loss.relock_cnt", int'(sup.relock_cnt), 1);
    for (int c = 0; c < 12; c++) applyStimulus(1'b1, 1'b0);
    checkOutput("loss.ready_e28", int'(sup.ready), 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("loss.ready_e29", int'(sup.ready), 1);
`else
    expectNow("loss.e16", 1, 1, 0, 1, 0);
    checkOutput("loss.relock_cnt", int'(sup.relock_cnt), 0);
    for (int c = 0; c < 5; c++) applyStimulus(1'b1, 1'b0);
    checkOutput("loss.fault_sticky", int'(sup.fault), 1);
`endif

    // Reset mid-STABLE, then the full sequence again.
    doReset();
    for (int c = 0; c < 8; c++) applyStimulus(1'b1, 1'b0);
    checkOutput("midrst.pll_reset_e8", int'(sup.pll_reset), 0);
    #2;
    doReset();
    for (int c = 0; c < 12; c++) applyStimulus(1'b1, 1'b0);
    checkOutput("midrst.ready_e12", int'(sup.ready), 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("midrst.ready_e13", int'(sup.ready), 1);

    // force_relock on the edge STABLE completes: PLL_RST wins, no ready.
    doReset();
    for (int c = 0; c < 12; c++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    expectNow("simul.e13", 1, 1, 0, 0, 0);
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("simul.no_ready", int'(sup.ready), 0);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("simul.ready_e26", int'(sup.ready), 1);

    // Randomised lock segments with occasional relock requests.
    doReset();
    lockVal = 1'b0;
    segLeft = 0;
    for (int c = 0; c < 1500; c++) begin
      if (segLeft == 0) begin
        lockVal = 1'($urandom_range(0, 1));
        segLeft = lockVal ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 40));
      end
      segLeft--;
      applyStimulus(lockVal, 1'($urandom_range(0, 59) == 0));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the Gowin rPLL after power-up and keeps it supervised in operation. It drives the PLL `RESET` input, synchronises the asynchronous `LOCK` output, and qualifies lock as stable. It then releases a reset request for the logic running on the PLL output clocks. The block runs on the PLL reference clock `clkin` and sits between the board reset and the rPLL wrapper. Retries on lock timeout, fault reporting and an optional automatic relock are included.

## Interface
- `RESET_CYCLES`, default 16: number of `clkin` cycles `pll_reset` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, default 65536: cycles allowed in WAIT_LOCK before the attempt fails (≥2).
- `STABLE_CYCLES`, default 1024: consecutive synchronised-lock-high cycles required before RUN (≥1).
- `MAX_RETRIES`, default 3: failed attempts before FAULT (≥1).

Ports (clock and reset first):
- `clkin` in 1: single clock for the whole block, the PLL reference clock.
- `rst` in 1: reset, asynchronous and active-high. Everything else is synchronous to `clkin`.
- `pll_lock` in 1: rPLL `LOCK`, asynchronous. Synchronised internally by two flops into `lock_s`.
- `force_relock` in 1: single-cycle request to restart the sequence from PLL_RST.
- `pll_reset` out 1: drives rPLL `RESET`.
- `sys_rst` out 1: reset request for the downstream clock domains. Active-high, deasserted only in RUN.
- `ready` out 1: high only in RUN.
- `fault` out 1: high only in FAULT.
- `retry_cnt` out `$clog2(MAX_RETRIES+1)`: failed attempts since the last successful lock or the last `force_relock`.
- `relock_cnt` out 8: count of RUN→PLL_RST transitions. Saturates at 255; cleared only by `rst`.

## Operation
States, encoded in the registered `state`. All outputs are Moore-decoded from registers.
- **PLL_RST:** `pll_reset`=1, `sys_rst`=1.
  - Counter counts `RESET_CYCLES`, then → WAIT_LOCK with the counter cleared.
- **WAIT_LOCK:** `pll_reset`=0, `sys_rst`=1.
  - `lock_s`=1 → STABLE, counter cleared.
  - Counter reaches `LOCK_TIMEOUT`-1 with `lock_s`=0 → `retry_cnt`+1.
  - If the new count equals `MAX_RETRIES` → FAULT, otherwise → PLL_RST.
- **STABLE:** `pll_reset`=0, `sys_rst`=1.
  - `lock_s`=0 → WAIT_LOCK with the counter cleared. `retry_cnt` is unchanged, and the WAIT_LOCK timeout restarts.
  - `STABLE_CYCLES` consecutive high cycles → RUN, `retry_cnt` cleared.
- **RUN:** `pll_reset`=0, `sys_rst`=0, `ready`=1.
  - `lock_s`=0 → behaviour per Configuration.
- **FAULT:** `pll_reset`=1, `sys_rst`=1, `fault`=1.
  - Sticky. Left only by `rst` or `force_relock`.

Global rules:
- `force_relock`=1 in any state → PLL_RST next cycle, counter and `retry_cnt` cleared. It has priority over every other transition in that cycle.
- One shared counter is sized for max(`RESET_CYCLES`, `LOCK_TIMEOUT`, `STABLE_CYCLES`). It never wraps, because each state leaves at its terminal count.
- `retry_cnt` never exceeds `MAX_RETRIES`.

## Timing
- **Reset values, while `rst`=1:**
  - state PLL_RST, counter 0
  - `pll_reset`=1, `sys_rst`=1, `ready`=0, `fault`=0
  - `retry_cnt`=0, `relock_cnt`=0
  - sync flops 0
- **`rst` asserted mid-operation:** immediate return to reset values regardless of state. No partial release of `sys_rst` is possible.
- **Lock input latency:** `pll_lock` to `lock_s` is 2 cycles, which adds to every lock/unlock reaction.
- **Best-case path, `pll_lock` constantly high:** measured from the first edge after `rst` deasserts.
  - PLL_RST lasts `RESET_CYCLES` cycles.
  - WAIT_LOCK lasts 1 cycle.
  - STABLE lasts `STABLE_CYCLES` cycles.
  - `ready` rises and `sys_rst` falls on edge `RESET_CYCLES`+1+`STABLE_CYCLES`.
- **Failed attempt length:** `RESET_CYCLES`+`LOCK_TIMEOUT` cycles.
- **Lock loss in RUN:** `ready` falls and `sys_rst` rises 3 cycles after `pll_lock` falls (2 sync + 1 state).
- **Crossing into the PLL output domain:** `sys_rst` is a level. The consumer synchronises its deassertion in its own domain.

## Configuration
- Macro `PLL_SUP_AUTORELOCK_EN`.
- **Defined:** `lock_s`=0 in RUN → PLL_RST, `retry_cnt` cleared, `relock_cnt`+1 (saturating).
- **Undefined:** `lock_s`=0 in RUN → FAULT. `relock_cnt` is tied to 0 and its logic is removed.

## Test plan
All scenarios use `RESET_CYCLES`=4, `LOCK_TIMEOUT`=16, `STABLE_CYCLES`=8, `MAX_RETRIES`=3.
- **Clean start:** `pll_lock`=1 from reset.
  - `pll_reset` falls on edge 4.
  - `ready`=1 and `sys_rst`=0 on edge 13.
  - `retry_cnt`=0, `fault`=0.
- **Lock never arrives:** `pll_lock`=0.
  - `pll_reset` pulses 3 times.
  - `retry_cnt` steps 1, 2, 3.
  - `fault`=1 on edge 60 and stays set with `pll_reset`=1.
  - `force_relock` then gives `retry_cnt`=0 and PLL_RST.
- **Glitchy lock:** lock high 5 cycles, low 1 cycle, then high.
  - Back to WAIT_LOCK, then STABLE restarts.
  - `ready` occurs 8 full cycles after the final rise plus sync latency.
  - `retry_cnt` stays 0.
- **Lock loss in RUN:** drop `pll_lock` for 2 cycles.
  - `ready` falls 3 cycles later.
  - With `PLL_SUP_AUTORELOCK_EN`: `relock_cnt`=1 and `ready` returns 13 cycles after the re-entry to PLL_RST, with lock high.
  - Without the macro: `fault`=1 and `relock_cnt`=0.
- **Reset mid-STABLE:** assert `rst` during STABLE.
  - All outputs take their reset values asynchronously.
  - After release, the full 13-cycle sequence repeats.
- **Simultaneous events:** `force_relock` on the same cycle the STABLE count completes.
  - The next state is PLL_RST, not RUN.
  - `ready` never pulses.
